// File: rtl/qc_parity_accum.sv
// qc_parity_accum
//   Quasi-cyclic LDPC parity accumulator. Takes a bit-serial information frame
//   of cfg_ngrp groups of Z bits. For every accepted 1-bit the current
//   generator row is XORed into a Z-bit parity register; the row rotates
//   right by one position after every accepted bit. Each group's generator
//   row is fetched from an external synchronous ROM at cfg_base + group.
//   After the last group the parity register is emitted serially, MSB first.
//
//   Build option: QCPA_SYSTEMATIC_EN
//     defined   - accepted info bits also pass through the output register,
//                 so the output frame is K info bits followed by Z parity
//                 bits. Output back-pressure stalls the input.
//     undefined - the output carries parity only; in_ready ignores out_ready.
//
// Parameters
//   Z        circulant size = parity width = bits per info group
//   NGRP_MAX maximum info groups per frame
//   AW       ROM address width
//   GW       width of cfg_ngrp
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start                  frame start pulse, honoured only while busy = 0
//   cfg_base, cfg_ngrp     ROM row base and group count, latched on start
//                          (cfg_ngrp of 0 or above NGRP_MAX selects NGRP_MAX)
//   in_valid/in_data       info bit stream, in_ready = block accepts a bit
//   rom_addr / rom_data    generator ROM port, data one cycle after address
//   out_valid/out_data/    registered output stream, out_last marks the
//   out_last/out_ready     final parity bit
//   busy                   high from accepted start until last bit consumed

module qc_parity_accum #(
    parameter int unsigned Z        = 360,
    parameter int unsigned NGRP_MAX = 12,
    parameter int unsigned AW       = 6,
    parameter int unsigned GW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] cfg_base,
    input  logic [GW-1:0] cfg_ngrp,
    input  logic          in_valid,
    input  logic          in_data,
    output logic          in_ready,
    output logic [AW-1:0] rom_addr,
    input  logic [Z-1:0]  rom_data,
    output logic          out_valid,
    output logic          out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy
);

    localparam int unsigned BW  = (Z > 1) ? $clog2(Z) : 1;
    localparam int unsigned GCW = $clog2(NGRP_MAX + 1);
    localparam logic [BW-1:0] B_LAST = BW'(Z - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_D,
        ACCUM,
        PAR
    } state_t;

    state_t          state;
    logic [AW-1:0]   base;
    logic [GCW-1:0]  g;
    logic [GCW-1:0]  g_last;
    logic [BW-1:0]   b;
    logic [Z-1:0]    parity;
    logic [Z-1:0]    gen;

    logic [GCW-1:0]  ngrp_last;
    int unsigned     ngrp_eff;
    logic [BW-1:0]   pidx;
    logic            out_ld;
    logic            accept;

    // Index of the last group for the requested frame length.
    always_comb begin
        ngrp_eff = NGRP_MAX;
        if (cfg_ngrp != '0 && 32'(cfg_ngrp) <= NGRP_MAX)
            ngrp_eff = 32'(cfg_ngrp);
        ngrp_last = GCW'(ngrp_eff - 1);
    end

    assign rom_addr = base + AW'(g);
    assign out_ld   = !out_valid || out_ready;
    assign busy     = (state != IDLE) || out_valid;
    assign pidx     = B_LAST - b;

`ifdef QCPA_SYSTEMATIC_EN
    assign in_ready = (state == ACCUM) && out_ld;
`else
    assign in_ready = (state == ACCUM);
`endif

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            g         <= '0;
            g_last    <= '0;
            b         <= '0;
            parity    <= '0;
            gen       <= '0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            // Consumed output empties the register unless a new bit loads below.
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        base   <= cfg_base;
                        g_last <= ngrp_last;
                        g      <= '0;
                        b      <= '0;
                        parity <= '0;
                        state  <= LOAD_A;
                    end
                end

                LOAD_A: state <= LOAD_D;

                LOAD_D: begin
                    gen   <= rom_data;
                    state <= ACCUM;
                end

                ACCUM: begin
                    if (accept) begin
                        if (in_data)
                            parity <= parity ^ gen;
                        gen <= {gen[0], gen[Z-1:1]};
`ifdef QCPA_SYSTEMATIC_EN
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                        out_last  <= 1'b0;
`endif
                        if (b == B_LAST) begin
                            b     <= '0;
                            g     <= g + 1'b1;
                            state <= (g == g_last) ? PAR : LOAD_A;
                        end else begin
                            b <= b + 1'b1;
                        end
                    end
                end

                PAR: begin
                    // b doubles as the parity bit pointer, MSB first.
                    if (out_ld) begin
                        out_valid <= 1'b1;
                        out_data  <= parity[pidx];
                        out_last  <= (b == B_LAST);
                        if (b == B_LAST) begin
                            b     <= '0;
                            state <= IDLE;
                        end else begin
                            b <= b + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qc_parity_accum.sv
// Self-checking bench for qc_parity_accum with Z=8, NGRP_MAX=2.
// A behavioural model computes the parity of each frame directly as the XOR
// of right-rotated generator rows selected by the 1-bits of the frame.
module tb_qc_parity_accum;

    localparam int Z    = 8;
    localparam int NG   = 2;
    localparam int AW   = 6;
    localparam int GW   = 4;
    localparam int KMAX = NG * Z;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [GW-1:0] cfg_ngrp = '0;
    logic          in_valid = 1'b0;
    logic          in_data = 1'b0;
    logic          in_ready;
    logic [AW-1:0] rom_addr;
    logic [Z-1:0]  rom_data;
    logic          out_valid;
    logic          out_data;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          busy;

    qc_parity_accum #(.Z(Z), .NGRP_MAX(NG), .AW(AW), .GW(GW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_base(cfg_base), .cfg_ngrp(cfg_ngrp),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [Z-1:0] rom [2**AW];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int n_cmp = 0;
    int n_err = 0;
    bit got_d[$];
    bit got_l[$];
    bit hold_pend = 1'b0;
    logic hold_d = 1'b0;
    bit gaps = 1'b0;
    logic [3:0] pat = 4'b1001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output collector and stall-stability checker.
    always @(negedge clk) begin
        if (rst_n && hold_pend) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(hold_d));
        end
        hold_pend = rst_n && out_valid && !out_ready;
        hold_d    = out_data;
        if (rst_n && out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
    end

    function automatic logic [Z-1:0] rotr(input logic [Z-1:0] r, input int j);
        return (r >> j) | (r << (Z - j));
    endfunction

    function automatic int eff_groups(input int ng);
        return (ng == 0 || ng > NG) ? NG : ng;
    endfunction

    function automatic logic [Z-1:0] model_parity(input int base, input int ng,
                                                  input logic [KMAX-1:0] info);
        logic [Z-1:0] acc = '0;
        for (int k = 0; k < eff_groups(ng) * Z; k++)
            if (1'(info >> k))
                acc ^= rotr(rom[AW'(base + k / Z)], k % Z);
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int mode, input int i);
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'(pat >> (i % 4));
            default: out_ready = 1'($urandom);
        endcase
        #1;
    endtask

    task automatic send_bit(input bit d, input int mode);
        int w = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 1'($urandom);
                set_ready(mode, 0);
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        set_ready(mode, w);
`ifdef QCPA_SYSTEMATIC_EN
        if (out_valid && !out_ready) check("in_ready_bp", 32'(in_ready), 0);
`endif
        while (!in_ready && w < 200) begin
            tick();
            w++;
            set_ready(mode, w);
`ifdef QCPA_SYSTEMATIC_EN
            if (out_valid && !out_ready) check("in_ready_bp", 32'(in_ready), 0);
`endif
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start(input int base, input int ng, input bit timing);
        int w = 0;
        while (busy && w < 1000) begin
            tick();
            w++;
        end
        check("idle_before_start", 32'(busy), 0);
        out_ready = 1'b1;
        cfg_base  = AW'(base);
        cfg_ngrp  = GW'(ng);
        start     = 1'b1;
        tick();
        start    = 1'b0;
        cfg_base = AW'($urandom);
        cfg_ngrp = GW'($urandom);
        if (timing) begin
            check("T1_rom_addr", 32'(rom_addr), 32'(base));
            check("T1_in_ready", 32'(in_ready), 0);
            check("T1_busy", 32'(busy), 1);
            tick();
            check("T2_in_ready", 32'(in_ready), 0);
            tick();
            check("T3_in_ready", 32'(in_ready), 1);
        end
    endtask

    task automatic run_frame(input int base, input int ng, input logic [KMAX-1:0] info,
                             input bit timing, input int bp, input bit poke,
                             output logic [Z-1:0] gp);
        int k_n   = eff_groups(ng) * Z;
        int in_md = (bp == 2) ? 2 : 0;
        int exp_n;
        int off;
        int w = 0;
        logic [Z-1:0] mp;
        bit eb;
        mp = model_parity(base, ng, info);
`ifdef QCPA_SYSTEMATIC_EN
        off = k_n;
`else
        off = 0;
`endif
        exp_n = off + Z;
        do_start(base, ng, timing);
        got_d.delete();
        got_l.delete();
        for (int k = 0; k < k_n; k++) begin
            send_bit(1'(info >> k), in_md);
            if (poke && k == 0) begin
                start    = 1'b1;
                cfg_base = AW'(base + 7);
                cfg_ngrp = GW'(1);
                tick();
                start = 1'b0;
                check("busy_start_rom_addr", 32'(rom_addr), 32'(AW'(base)));
            end
            if (timing && (k % Z) == Z - 1 && k != k_n - 1) begin
                check("gap1_in_ready", 32'(in_ready), 0);
                check("gap_rom_addr", 32'(rom_addr), 32'(AW'(base + k / Z + 1)));
                tick();
                check("gap2_in_ready", 32'(in_ready), 0);
                tick();
                check("gap3_in_ready", 32'(in_ready), 1);
            end
        end
`ifndef QCPA_SYSTEMATIC_EN
        if (timing) begin
            check("par_E1_valid", 32'(out_valid), 0);
            tick();
            check("par_E2_valid", 32'(out_valid), 1);
            check("par_E2_data", 32'(out_data), 32'(mp[Z-1]));
        end
`endif
        while (got_d.size() < exp_n && w < 500) begin
            set_ready(bp, w);
            tick();
            w++;
        end
        out_ready = 1'b1;
        check("busy_after_last", 32'(busy), 0);
        check("out_count", got_d.size(), exp_n);
        gp = '0;
        for (int i = 0; i < exp_n && i < got_d.size(); i++) begin
            eb = (i < off) ? 1'(info >> i) : 1'(mp >> (Z - 1 - (i - off)));
            check("out_bit", 32'(got_d[i]), 32'(eb));
            check("out_last_flag", 32'(got_l[i]), 32'(i == exp_n - 1));
            if (i >= off) gp = {gp[Z-2:0], got_d[i]};
        end
        check("parity_word", 32'(gp), 32'(mp));
    endtask

    initial begin
        logic [Z-1:0] gp;
        logic [Z-1:0] gp_first;
        logic [KMAX-1:0] basic = 16'h01FF;
        for (int i = 0; i < 2**AW; i++) rom[i] = Z'($urandom);
        rom[0] = 8'h01;
        rom[1] = 8'h03;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        #1 rst_n = 1'b1;
        tick();

        // Basic accumulate with known rows
        gaps = 1'b0;
        run_frame(0, 2, basic, 1'b1, 0, 1'b0, gp);
        check("basic_parity_FC", 32'(gp), 32'h00FC);
        gp_first = gp;

        // ROM addressing and group gap timing from a non-zero base
        run_frame(5, 2, KMAX'($urandom), 1'b1, 0, 1'b0, gp);

        // Back-pressure pattern 1,0,0,1 while parity drains
        run_frame(5, 2, KMAX'($urandom), 1'b0, 1, 1'b0, gp);

        // cfg_ngrp = 0 and over-range, start pulsed while busy
        run_frame(10, 0, KMAX'($urandom), 1'b0, 2, 1'b1, gp);
        run_frame(20, 3, KMAX'($urandom), 1'b0, 1, 1'b0, gp);
        run_frame(33, 1, KMAX'($urandom), 1'b1, 0, 1'b0, gp);

        // Reset in the middle of group 1
        do_start(0, 2, 1'b0);
        for (int k = 0; k < 11; k++) send_bit(1'(basic >> k), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_data", 32'(out_data), 0);
        check("midrst_out_last", 32'(out_last), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rom_addr", 32'(rom_addr), 0);
        hold_pend = 1'b0;
        #1 rst_n = 1'b1;
        got_d.delete();
        got_l.delete();
        tick();
        run_frame(0, 2, basic, 1'b1, 0, 1'b0, gp);
        check("post_reset_same", 32'(gp), 32'(gp_first));

        // Randomised frames with input gaps and random output readiness
        gaps = 1'b1;
        for (int r = 0; r < 6; r++)
            run_frame(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)),
                      KMAX'($urandom), 1'b0, 2, 1'b0, gp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
